// File: rtl/retire_checker_if.sv
`default_nettype none
// ============================================================================
// Module      : retire_checker_if
// Description : Retire stream plus spare register-file read port shared by the
//               core side (master) and the retire checker (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface retire_checker_if;
  logic        wb_valid;
  logic [31:0] wb_pc;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;

  // Core / testbench side: produces retires and answers register reads.
  modport master (
    output wb_valid,
    output wb_pc,
    output rf_rdata,
    input  rf_raddr
  );

  // Checker side: observes retires and issues register reads.
  modport slave (
    input  wb_valid,
    input  wb_pc,
    input  rf_rdata,
    output rf_raddr
  );
endinterface
`default_nettype wire

// File: rtl/retire_checker.sv
`default_nettype none
// ============================================================================
// Module      : retire_checker
// Description : Ordered retire-PC checkpoint checker. When checkpoint idx's PC
//               retires, the register named by the checkpoint is read one cycle
//               later through a spare read port and compared with the expected
//               value. Reports PASS when all checkpoints match, FAIL on a
//               mismatch or on a global cycle timeout.
// Options     : RETIRE_CHK_CONTINUE_EN - keep going after a mismatch, count
//               mismatches on err_cnt_o, record the first failing index.
// Revision    : 1.0 - initial release
// ============================================================================
module retire_checker #(
  parameter int NUM_CHK     = 4,
  parameter int CNT_W       = 20,
  parameter int TIMEOUT_CYC = 100000,
  localparam int IDX_W      = (NUM_CHK > 1) ? $clog2(NUM_CHK) : 1
) (
  input  logic                   clk,
  input  logic                   resetn,
  retire_checker_if.slave        bus,
  input  logic [NUM_CHK*32-1:0]  chk_pc_i,
  input  logic [NUM_CHK*5-1:0]   chk_ridx_i,
  input  logic [NUM_CHK*32-1:0]  chk_val_i,
  output logic                   done_o,
  output logic                   pass_o,
  output logic [IDX_W-1:0]       fail_idx_o,
  output logic [1:0]             fail_cause_o,
`ifdef RETIRE_CHK_CONTINUE_EN
  output logic [IDX_W:0]         err_cnt_o,
`endif
  output logic [CNT_W-1:0]       cycle_cnt_o
);

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_CMP  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0]       C_CAUSE_NONE     = 2'b00;
  localparam logic [1:0]       C_CAUSE_MISMATCH = 2'b01;
  localparam logic [1:0]       C_CAUSE_TIMEOUT  = 2'b10;
  localparam logic [IDX_W-1:0] C_LAST_IDX       = IDX_W'(NUM_CHK - 1);
  localparam bit               C_TO_EN          = (TIMEOUT_CYC != 0);
  localparam logic [CNT_W-1:0] C_TO_LAST        = CNT_W'(TIMEOUT_CYC - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             pend_q, pend_d;
  logic             pass_q, pass_d;
  logic [IDX_W-1:0] fidx_q, fidx_d;
  logic [1:0]       cause_q, cause_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef RETIRE_CHK_CONTINUE_EN
  logic [IDX_W:0]   err_q, err_d;
`endif

  // Flattened checkpoint tables, one entry per checkpoint.
  logic [31:0] w_pc_arr   [NUM_CHK];
  logic [4:0]  w_ridx_arr [NUM_CHK];
  logic [31:0] w_val_arr  [NUM_CHK];

  for (genvar k = 0; k < NUM_CHK; k++) begin : g_unpack
    assign w_pc_arr[k]   = chk_pc_i[k*32 +: 32];
    assign w_ridx_arr[k] = chk_ridx_i[k*5 +: 5];
    assign w_val_arr[k]  = chk_val_i[k*32 +: 32];
  end

  logic             w_last;
  logic [IDX_W-1:0] w_nidx;
  logic             w_match;
  logic             w_cap;
  logic             w_eq;
  logic             w_to;

  assign w_last  = (idx_q == C_LAST_IDX);
  // Clamp so the "next checkpoint" lookup never leaves the table.
  assign w_nidx  = w_last ? idx_q : idx_q + 1'b1;
  assign w_match = bus.wb_valid && (bus.wb_pc == w_pc_arr[idx_q]);
  // Retire of the following checkpoint while the current one is being compared.
  assign w_cap   = (state_q == ST_CMP) && bus.wb_valid && !w_last &&
                   (bus.wb_pc == w_pc_arr[w_nidx]);
  assign w_eq    = (bus.rf_rdata == w_val_arr[idx_q]);
  // Timeout is only taken from WAIT so a compare in flight always decides
  // first; ">=" keeps it armed if a compare carried the counter past the mark.
  assign w_to    = C_TO_EN && (state_q == ST_WAIT) && (cnt_q >= C_TO_LAST);

  assign bus.rf_raddr = w_ridx_arr[idx_q];
  assign done_o       = (state_q == ST_DONE);
  assign pass_o       = pass_q;
  assign fail_idx_o   = fidx_q;
  assign fail_cause_o = cause_q;
  assign cycle_cnt_o  = cnt_q;
`ifdef RETIRE_CHK_CONTINUE_EN
  assign err_cnt_o    = err_q;
`endif

  // Next-state, checkpoint advance, verdict and cycle counter.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pend_d  = pend_q;
    pass_d  = pass_q;
    fidx_d  = fidx_q;
    cause_d = cause_q;
    cnt_d   = cnt_q;
`ifdef RETIRE_CHK_CONTINUE_EN
    err_d   = err_q;
`endif

    if ((state_q != ST_DONE) && !w_to && !(&cnt_q)) begin
      cnt_d = cnt_q + 1'b1;
    end

    case (state_q)
      ST_WAIT: begin
        if (w_to) begin
          state_d = ST_DONE;
          pass_d  = 1'b0;
`ifdef RETIRE_CHK_CONTINUE_EN
          // An earlier mismatch is the more useful diagnosis; keep it.
          if (cause_q == C_CAUSE_NONE) begin
            cause_d = C_CAUSE_TIMEOUT;
            fidx_d  = idx_q;
          end
`else
          cause_d = C_CAUSE_TIMEOUT;
          fidx_d  = idx_q;
`endif
        end else if (w_match) begin
          state_d = ST_CMP;
        end
      end

      ST_CMP: begin
        pend_d = pend_q | w_cap;
`ifdef RETIRE_CHK_CONTINUE_EN
        if (!w_eq) begin
          err_d = err_q + 1'b1;
          if (cause_q == C_CAUSE_NONE) begin
            cause_d = C_CAUSE_MISMATCH;
            fidx_d  = idx_q;
          end
        end
        if (w_last) begin
          state_d = ST_DONE;
          pass_d  = (err_d == '0);
        end else begin
          idx_d   = w_nidx;
          state_d = (pend_q || w_cap) ? ST_CMP : ST_WAIT;
          pend_d  = 1'b0;
        end
`else
        if (!w_eq) begin
          state_d = ST_DONE;
          pass_d  = 1'b0;
          cause_d = C_CAUSE_MISMATCH;
          fidx_d  = idx_q;
        end else if (w_last) begin
          state_d = ST_DONE;
          pass_d  = 1'b1;
        end else begin
          idx_d   = w_nidx;
          state_d = (pend_q || w_cap) ? ST_CMP : ST_WAIT;
          pend_d  = 1'b0;
        end
`endif
      end

      default: begin
        state_d = ST_DONE;
      end
    endcase
  end

  // State and verdict registers; reset wipes all progress.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_WAIT;
      idx_q   <= '0;
      pend_q  <= 1'b0;
      pass_q  <= 1'b0;
      fidx_q  <= '0;
      cause_q <= C_CAUSE_NONE;
      cnt_q   <= '0;
`ifdef RETIRE_CHK_CONTINUE_EN
      err_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      pass_q  <= pass_d;
      fidx_q  <= fidx_d;
      cause_q <= cause_d;
      cnt_q   <= cnt_d;
`ifdef RETIRE_CHK_CONTINUE_EN
      err_q   <= err_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_retire_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_retire_checker
// Description : Directed bench for retire_checker: a 1-checkpoint and a
//               2-checkpoint instance driven with hand-computed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_retire_checker;

  localparam logic [31:0] C_PC_A  = 32'h1c000060;
  localparam logic [31:0] C_PC_C0 = 32'h1c000010;
  localparam logic [31:0] C_PC_C1 = 32'h1c000014;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic [31:0] regs [32];

  retire_checker_if b1();
  retire_checker_if b2();

  assign b1.rf_rdata = regs[b1.rf_raddr];
  assign b2.rf_rdata = regs[b2.rf_raddr];

  logic [31:0] pc1;
  logic [4:0]  ridx1;
  logic [31:0] val1;
  logic [63:0] pc2;
  logic [9:0]  ridx2;
  logic [63:0] val2;

  logic        u1_done, u1_pass, u2_done, u2_pass;
  logic [0:0]  u1_fidx, u2_fidx;
  logic [1:0]  u1_cause, u2_cause;
  logic [19:0] u1_cnt, u2_cnt;
`ifdef RETIRE_CHK_CONTINUE_EN
  logic [1:0]  u1_err, u2_err;
`endif

  retire_checker #(.NUM_CHK(1), .CNT_W(20), .TIMEOUT_CYC(50)) u1 (
    .clk          (clk),
    .resetn       (resetn),
    .bus          (b1),
    .chk_pc_i     (pc1),
    .chk_ridx_i   (ridx1),
    .chk_val_i    (val1),
    .done_o       (u1_done),
    .pass_o       (u1_pass),
    .fail_idx_o   (u1_fidx),
    .fail_cause_o (u1_cause),
`ifdef RETIRE_CHK_CONTINUE_EN
    .err_cnt_o    (u1_err),
`endif
    .cycle_cnt_o  (u1_cnt)
  );

  retire_checker #(.NUM_CHK(2), .CNT_W(20), .TIMEOUT_CYC(50)) u2 (
    .clk          (clk),
    .resetn       (resetn),
    .bus          (b2),
    .chk_pc_i     (pc2),
    .chk_ridx_i   (ridx2),
    .chk_val_i    (val2),
    .done_o       (u2_done),
    .pass_o       (u2_pass),
    .fail_idx_o   (u2_fidx),
    .fail_cause_o (u2_cause),
`ifdef RETIRE_CHK_CONTINUE_EN
    .err_cnt_o    (u2_err),
`endif
    .cycle_cnt_o  (u2_cnt)
  );

  int total = 0;
  int bad   = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    b1.wb_valid = 1'b0;
    b2.wb_valid = 1'b0;
    resetn = 1'b0;
    step();
    step();
    resetn = 1'b1;
  endtask

  initial begin
    int n;
    logic exp_d2;
    for (int i = 0; i < 32; i++) regs[i] = 32'h0;
    pc1   = C_PC_A;
    ridx1 = 5'd5;
    val1  = 32'h5a;
    pc2   = {C_PC_C1, C_PC_C0};
    ridx2 = {5'd7, 5'd3};
    val2  = {32'h22, 32'h11};
    b1.wb_pc = 32'h0;
    b2.wb_pc = 32'h0;

    // Reset state
    do_reset();
    chk("rst_done", u1_done, 0);
    chk("rst_pass", u1_pass, 0);
    chk("rst_cause", u1_cause, 0);
    chk("rst_fidx", u1_fidx, 0);
    chk("rst_cnt", u1_cnt, 0);
    chk("rst_raddr1", b1.rf_raddr, 5);
    chk("rst_raddr2", b2.rf_raddr, 3);
`ifdef RETIRE_CHK_CONTINUE_EN
    chk("rst_err", u1_err, 0);
`endif

    // Single checkpoint, correct value
    regs[5] = 32'h5a;
    step();
    b1.wb_valid = 1'b1; b1.wb_pc = C_PC_A;
    step();
    b1.wb_valid = 1'b0;
    chk("t1_done_n1", u1_done, 0);
    step();
    chk("t1_done_n2", u1_done, 1);
    chk("t1_pass", u1_pass, 1);
    chk("t1_cause", u1_cause, 0);
    b1.wb_valid = 1'b1;
    step();
    b1.wb_valid = 1'b0;
    step();
    chk("t1_sticky_done", u1_done, 1);
    chk("t1_sticky_pass", u1_pass, 1);

    // Single checkpoint, wrong value
    do_reset();
    regs[5] = 32'h5b;
    b1.wb_valid = 1'b1; b1.wb_pc = C_PC_A;
    step();
    b1.wb_valid = 1'b0;
    step();
    chk("t2_done", u1_done, 1);
    chk("t2_pass", u1_pass, 0);
    chk("t2_cause", u1_cause, 1);
    chk("t2_fidx", u1_fidx, 0);
`ifdef RETIRE_CHK_CONTINUE_EN
    chk("t2_err", u1_err, 1);
`endif

    // Two checkpoints back to back (pending capture)
    do_reset();
    regs[3] = 32'h11; regs[7] = 32'h22;
    b2.wb_valid = 1'b1; b2.wb_pc = C_PC_C0;
    step();
    b2.wb_pc = C_PC_C1;
    step();
    b2.wb_valid = 1'b0;
    chk("t3_done_n2", u2_done, 0);
    chk("t3_raddr_idx1", b2.rf_raddr, 7);
    step();
    chk("t3_done_n3", u2_done, 1);
    chk("t3_pass", u2_pass, 1);

    // Out-of-order retire is ignored
    do_reset();
    b2.wb_valid = 1'b1; b2.wb_pc = C_PC_C1;
    step();
    b2.wb_valid = 1'b0;
    step(); step();
    chk("t4_ooo_done", u2_done, 0);
    chk("t4_ooo_raddr", b2.rf_raddr, 3);
    b2.wb_valid = 1'b1; b2.wb_pc = C_PC_C0;
    step();
    b2.wb_valid = 1'b0;
    step(); step();
    chk("t4_mid_done", u2_done, 0);
    chk("t4_mid_raddr", b2.rf_raddr, 7);
    b2.wb_valid = 1'b1; b2.wb_pc = C_PC_C1;
    step();
    b2.wb_valid = 1'b0;
    step();
    chk("t4_done", u2_done, 1);
    chk("t4_pass", u2_pass, 1);

    // Timeout: u1 never sees its PC, u2 passes checkpoint 0 then stalls
    do_reset();
    b2.wb_valid = 1'b1; b2.wb_pc = C_PC_C0;
    n = 0;
    for (int i = 0; i < 80 && u1_done !== 1'b1; i++) begin
      step();
      n++;
      b2.wb_valid = 1'b0;
    end
    chk("t5_edges", n, 50);
    chk("t5_done", u1_done, 1);
    chk("t5_pass", u1_pass, 0);
    chk("t5_cause", u1_cause, 2);
    chk("t5_fidx", u1_fidx, 0);
    chk("t5_cnt", u1_cnt, 49);
    chk("t5_u2_done", u2_done, 1);
    chk("t5_u2_cause", u2_cause, 2);
    chk("t5_u2_fidx", u2_fidx, 1);
    for (int i = 0; i < 5; i++) step();
    chk("t5_cnt_hold", u1_cnt, 49);

    // Reset in the middle of a compare
    do_reset();
    b2.wb_valid = 1'b1; b2.wb_pc = C_PC_C0;
    step();
    b2.wb_pc = C_PC_C1;
    step();
    b2.wb_valid = 1'b0;
    chk("t6_pre_raddr", b2.rf_raddr, 7);
    resetn = 1'b0;
    #1;
    chk("t6_rst_raddr", b2.rf_raddr, 3);
    chk("t6_rst_done", u2_done, 0);
    chk("t6_rst_cnt", u2_cnt, 0);
    step();
    resetn = 1'b1;
    b2.wb_valid = 1'b1; b2.wb_pc = C_PC_C0;
    step();
    b2.wb_pc = C_PC_C1;
    step();
    b2.wb_valid = 1'b0;
    step();
    chk("t6_done", u2_done, 1);
    chk("t6_pass", u2_pass, 1);

    // Mismatch on checkpoint 0 only
    do_reset();
    regs[3] = 32'h99;
    b2.wb_valid = 1'b1; b2.wb_pc = C_PC_C0;
    step();
    b2.wb_pc = C_PC_C1;
    step();
    b2.wb_valid = 1'b0;
`ifdef RETIRE_CHK_CONTINUE_EN
    exp_d2 = 1'b0;
`else
    exp_d2 = 1'b1;
`endif
    chk("t7_done_n2", u2_done, exp_d2);
    step();
    chk("t7_done", u2_done, 1);
    chk("t7_pass", u2_pass, 0);
    chk("t7_cause", u2_cause, 1);
    chk("t7_fidx", u2_fidx, 0);
`ifdef RETIRE_CHK_CONTINUE_EN
    chk("t7_err", u2_err, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
